tmr_sipo_receiver: RTL and testbench
====================================

Name: tmr_sipo_receiver

Overview:
Triple-modular-redundant serial-to-parallel receiver. It is the receive end of the serial stream produced by the TMR shift register in PISO mode (LSB first, one bit per enabled cycle). It assembles width-bit words and presents them on a valid/ready output. Shift data, bit counter and FSM state are each triplicated and majority-voted, and any replica that disagrees with the vote is rewritten from the voted value every cycle.

Parameters:
width, 8, word length in bits (>= 2)
lsb_first, 1, 1: the first received bit lands in bit 0 (mates PISO right shift); 0: the first received bit lands in bit width-1

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active high
enable  input  1  bit strobe; serial_in and start are sampled only on cycles with enable=1
start  input  1  frame marker, high together with the first bit of a word
serial_in  input  1  serial data
out_ready  input  1  consumer accepts the word when out_valid=1 and out_ready=1
inj_flip  input  3  test only: bit i=1 inverts bit 0 of replica i's shift register at the next edge
parallel_out  output  width  voted received word, held stable while out_valid=1
out_valid  output  1  word available
busy  output  1  voted FSM state is SHIFT
overrun  output  1  sticky: a word was dropped because the output was still occupied
fault  output  3  registered per-replica mismatch flags, set for one cycle after the replica disagreed with the vote

Behaviour:
- Reset (rst=1 at a clk edge):
  - All three replicas cleared: state IDLE, count 0, shift 0.
  - parallel_out=0, out_valid=0, busy=0, overrun=0, fault=0.
  - Reset wins over every other input, including mid-frame; a partial word is discarded.
- Replica content: state {IDLE, SHIFT}, count [$clog2(width)-1:0], shift [width-1:0].
- Voting and correction:
  - Bitwise 2-of-3 majority on state, count and shift every cycle.
  - Each replica's next value is computed from the voted values, so a single upset is scrubbed within one cycle.
  - fault[i] is registered: mismatch of replica i on any field in cycle N gives fault[i]=1 in cycle N+1.
- FSM, evaluated only on enable=1 cycles (no state change when enable=0):
  - IDLE, start=1: capture serial_in as bit 0 (lsb_first=1: shift <= {serial_in, shift[width-1:1]}; otherwise shift <= {shift[width-2:0], serial_in}), set count=1, go to SHIFT. start=0 in IDLE: no change.
  - SHIFT, count<width-1: shift in serial_in, count+1.
  - SHIFT, count==width-1: shift in the final bit, form the word, count=0.
    - If start=1 this cycle, the word still completes; start is ignored in SHIFT.
    - Next state is IDLE.
- Word completion (the cycle the final bit is shifted):
  - If out_valid=0, or out_valid=1 and out_ready=1 in the same cycle: parallel_out <= assembled word, out_valid=1 on the next cycle.
  - Otherwise the word is dropped, parallel_out is unchanged and overrun <= 1. overrun clears only on rst.
- Handshake:
  - out_valid=1 and out_ready=1 with no completion that cycle: out_valid <= 0.
  - parallel_out is not modified while out_valid=1 except by the simultaneous accept-and-complete case above.
- Latency: out_valid rises on the clk edge following the enabled cycle that carried the last bit.
- Back-to-back frames: start may be asserted on the enabled cycle right after completion, giving zero idle bits between words.
- busy is derived from the voted state and is combinational from registers.
- inj_flip applies after correction and affects only the chosen replica. Two simultaneous flips on the same bit corrupt the vote; this is out of the fault model, and the block need only not hang.

Test Plan:
1. rst 1 for 2 cycles, then enable=1, start=1 with bits 1,0,1,0,0,1,0,1 (LSB first, width=8, lsb_first=1) -> one cycle after the 8th bit: out_valid=1, parallel_out=8'hA5, busy=0, overrun=0.
2. Same frame with enable toggled 1,0,1,0… -> identical 8'hA5; busy remains 1 across enable=0 gaps; completion occurs 15 cycles after start.
3. Two back-to-back frames 8'h3C then 8'hC3, out_ready held 0 -> parallel_out stays 8'h3C, overrun=1. Then pulse out_ready -> out_valid=0, overrun stays 1 until rst.
4. inj_flip=3'b010 mid-frame on bit 4 of a frame of 8'hFF -> fault=3'b010 for exactly one cycle; received word 8'hFF; no extra faults afterwards.
5. rst asserted after 5 bits of a frame -> next cycle all outputs 0. A new frame 8'h81 is then received correctly.
6. out_valid=1 with out_ready=1 on the exact completion cycle of the next frame 8'h7E -> out_valid stays 1, parallel_out=8'h7E, overrun=0.

Source files
------------

// File: rtl/tmr_sipo_receiver.sv
// tmr_sipo_receiver: triplicated, self-scrubbing serial-to-parallel receiver with valid/ready output
module tmr_sipo_receiver #(
    parameter int width = 8,
    parameter bit lsb_first = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic             serial_in,
    input  logic             out_ready,
    input  logic [2:0]       inj_flip,
    output logic [width-1:0] parallel_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic [2:0]       fault
);
    localparam int CW = $clog2(width);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           st_q [3];
    logic [CW-1:0]    cnt_q [3];
    logic [width-1:0] sh_q [3];
    state_t           st_v, st_d;
    logic [CW-1:0]    cnt_v, cnt_d;
    logic [width-1:0] sh_v, sh_d, shifted, par_q;
    logic             complete, valid_q, ovr_q;
    logic [2:0]       mis_d, fault_q;
    // Vote the replicas, then derive one shared next state from the voted values
    always_comb begin
        st_v = state_t'((st_q[0] & st_q[1]) | (st_q[0] & st_q[2]) | (st_q[1] & st_q[2]));
        cnt_v = (cnt_q[0] & cnt_q[1]) | (cnt_q[0] & cnt_q[2]) | (cnt_q[1] & cnt_q[2]);
        sh_v = (sh_q[0] & sh_q[1]) | (sh_q[0] & sh_q[2]) | (sh_q[1] & sh_q[2]);
        shifted = lsb_first ? {serial_in, sh_v[width-1:1]} : {sh_v[width-2:0], serial_in};
        complete = enable && st_v == SHIFT && cnt_v == CW'(width - 1);
        st_d = (enable && st_v == IDLE && start) ? SHIFT : complete ? IDLE : st_v;
        sh_d = (enable && (st_v == SHIFT || start)) ? shifted : sh_v;
        cnt_d = !enable ? cnt_v : st_v == IDLE ? (start ? CW'(1) : cnt_v) : complete ? '0 : cnt_v + CW'(1);
        mis_d = '0;
        for (int i = 0; i < 3; i++)
            mis_d[i] = st_q[i] != st_v || cnt_q[i] != cnt_v || sh_q[i] != sh_v;
    end
    // Rewrite every replica from the vote; test injection flips bit 0 after correction
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            st_q[i] <= rst ? IDLE : st_d;
            cnt_q[i] <= rst ? '0 : cnt_d;
            sh_q[i] <= rst ? '0 : sh_d ^ {{(width-1){1'b0}}, inj_flip[i]};
        end
        fault_q <= rst ? 3'b000 : mis_d;
    end
    // Output holding register with valid/ready handshake and sticky overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= '0;
            valid_q <= 1'b0;
            ovr_q <= 1'b0;
        end else if (complete) begin
            if (!valid_q || out_ready) begin
                par_q <= shifted;
                valid_q <= 1'b1;
            end else begin
                ovr_q <= 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end
    assign parallel_out = par_q;
    assign out_valid = valid_q;
    assign busy = st_v == SHIFT;
    assign overrun = ovr_q;
    assign fault = fault_q;
endmodule

// File: tb/tb_tmr_sipo_receiver.sv
// tb_tmr_sipo_receiver: directed and random checks against a word-level reference model
module tb_tmr_sipo_receiver;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst, enable, start, serial_in, out_ready;
    logic [2:0] inj_flip, fault;
    logic [W-1:0] parallel_out;
    logic out_valid, busy, overrun;
    int npass = 0, ntot = 0, cyc = 0, fault_cycles = 0;
    bit m_frame = 0, m_valid = 0, m_ovr = 0;
    bit m_bits[$];
    logic [W-1:0] m_par = '0;
    logic [2:0] m_fault = '0, m_pend = '0;

    tmr_sipo_receiver #(.width(W), .lsb_first(1'b1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .serial_in(serial_in),
        .out_ready(out_ready), .inj_flip(inj_flip), .parallel_out(parallel_out),
        .out_valid(out_valid), .busy(busy), .overrun(overrun), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        ntot++;
        assert (got === exp) npass++;
        else $error("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    endtask

    // Word-level model: collect bits of a frame, then apply the output handshake rules
    task automatic model();
        logic [W-1:0] word = '0;
        bit done = 0;
        if (rst) begin
            m_frame = 0; m_bits.delete(); m_par = '0; m_valid = 0; m_ovr = 0; m_fault = '0; m_pend = '0;
            return;
        end
        m_fault = m_pend;
        m_pend = inj_flip;
        if (enable && (m_frame || start)) begin
            m_frame = 1;
            m_bits.push_back(serial_in);
            if (m_bits.size() == W) begin
                foreach (m_bits[k]) word[k] = m_bits[k];
                m_bits.delete();
                m_frame = 0;
                done = 1;
            end
        end
        if (done) begin
            if (!m_valid || out_ready) begin m_par = word; m_valid = 1; end
            else m_ovr = 1;
        end else if (m_valid && out_ready) m_valid = 0;
    endtask

    task automatic step(bit r, bit en, bit st, bit si, bit rdy, logic [2:0] inj);
        rst = r; enable = en; start = st; serial_in = si; out_ready = rdy; inj_flip = inj;
        @(posedge clk);
        model();
        #1;
        cyc++;
        if (fault !== 3'b000) fault_cycles++;
        chk("out_valid", out_valid, m_valid);
        chk("parallel_out", parallel_out, m_par);
        chk("busy", busy, m_frame);
        chk("overrun", overrun, m_ovr);
        chk("fault", fault, m_fault);
    endtask

    task automatic send(logic [W-1:0] w, bit gaps, bit rdy_last, int inj_at, logic [2:0] inj);
        for (int k = 0; k < W; k++) begin
            step(0, 1, k == 0, w[k], rdy_last && k == W - 1, k == inj_at ? inj : 3'b000);
            if (gaps && k < W - 1) step(0, 0, 0, 0, 0, 3'b000);
        end
    endtask

    initial begin
        int f0;
        step(1, 0, 0, 0, 0, 3'b000);
        step(1, 0, 0, 0, 0, 3'b000);
        chk("rst_valid", out_valid, 0);
        chk("rst_par", parallel_out, 0);
        send(8'hA5, 0, 0, -1, 3'b000);
        chk("t1_word", parallel_out, 8'hA5);
        chk("t1_valid", out_valid, 1);
        chk("t1_busy", busy, 0);
        chk("t1_ovr", overrun, 0);
        step(0, 0, 0, 0, 1, 3'b000);
        send(8'hA5, 1, 0, -1, 3'b000);
        chk("t2_word", parallel_out, 8'hA5);
        chk("t2_valid", out_valid, 1);
        step(0, 0, 0, 0, 1, 3'b000);
        send(8'h3C, 0, 0, -1, 3'b000);
        send(8'hC3, 0, 0, -1, 3'b000);
        chk("t3_word", parallel_out, 8'h3C);
        chk("t3_ovr", overrun, 1);
        step(0, 0, 0, 0, 1, 3'b000);
        chk("t3_valid_clr", out_valid, 0);
        chk("t3_ovr_sticky", overrun, 1);
        f0 = fault_cycles;
        send(8'hFF, 0, 0, 4, 3'b010);
        step(0, 0, 0, 0, 0, 3'b000);
        step(0, 0, 0, 0, 0, 3'b000);
        chk("t4_word", parallel_out, 8'hFF);
        chk("t4_fault_cycles", fault_cycles - f0, 1);
        step(0, 0, 0, 0, 1, 3'b000);
        for (int k = 0; k < 5; k++) step(0, 1, k == 0, 1'b1, 0, 3'b000);
        step(1, 0, 0, 0, 0, 3'b000);
        chk("t5_par", parallel_out, 0);
        chk("t5_valid", out_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ovr", overrun, 0);
        send(8'h81, 0, 0, -1, 3'b000);
        chk("t5_word", parallel_out, 8'h81);
        send(8'h7E, 0, 1, -1, 3'b000);
        chk("t6_valid", out_valid, 1);
        chk("t6_word", parallel_out, 8'h7E);
        chk("t6_ovr", overrun, 0);
        for (int n = 0; n < 600; n++)
            step($urandom_range(199) == 0, $urandom_range(3) != 0, $urandom_range(3) == 0,
                 1'($urandom), $urandom_range(2) == 0,
                 $urandom_range(19) == 0 ? 3'(1 << $urandom_range(2)) : 3'b000);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
